// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, synchronous instruction memory interface, prefetch buffer
// and the registered {PC_1, IR, branch_predict} triple handed to decode.
module instr_fetch_stage #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     IR_W     = 32,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [IR_W-1:0] NOP_IR   = '0
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            stall,
  input  logic            take_branch,
  input  logic [PC_W-1:0] BrA,
  output logic [PC_W-1:0] IM_addr,
  input  logic [IR_W-1:0] IM_data,
  output logic [PC_W-1:0] PC_1,
  output logic [IR_W-1:0] IR,
  output logic            branch_predict
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]  pc, pc_n;
  logic [PC_W-1:0]  inflight_pc, inflight_pc_n;
  logic             inflight, inflight_n;
  logic [CNT_W-1:0] count, count_n;
  logic [PTR_W-1:0] head, head_n, tail;
  logic [PC_W-1:0]  pc_1_n;
  logic [IR_W-1:0]  ir_n;
  logic             bp_n;
  logic             drain, issue_en, push, pop;
  logic [CNT_W:0]   occ_n;
  logic [PC_W-1:0]  ret_pc1;

  logic [PC_W-1:0]  buf_pc1 [DEPTH];
  logic [IR_W-1:0]  buf_ir  [DEPTH];

  assign IM_addr = pc;

  // Next-state: issue throttling, buffer bookkeeping and decode register load
  always_comb begin
    pc_n          = pc;
    inflight_pc_n = inflight_pc;
    head_n        = head;
    pc_1_n        = PC_1;
    ir_n          = IR;
    bp_n          = branch_predict;

    ret_pc1  = inflight_pc + PC_W'(1);
    drain    = ~stall & ((count != '0) | inflight);
    occ_n    = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(drain);
    issue_en = ~take_branch & (occ_n < (CNT_W+1)'(DEPTH));
    pop      = ~take_branch & ~stall & (count != '0);
    push     = ~take_branch & inflight & (stall | (count != '0));
    tail     = head + PTR_W'(count);

    inflight_n = issue_en;
    count_n    = take_branch ? '0 : CNT_W'(occ_n);

    if (issue_en) begin
      inflight_pc_n = pc;
      pc_n          = pc + PC_W'(1);
    end

    if (pop) head_n = head + PTR_W'(1);

    if (take_branch) begin
      // Redirect: word returning next cycle belongs to the wrong path
      pc_n   = BrA;
      head_n = '0;
      ir_n   = NOP_IR;
      bp_n   = 1'b0;
    end else if (!stall) begin
      if (count != '0) begin
        pc_1_n = buf_pc1[head];
        ir_n   = buf_ir[head];
        bp_n   = 1'b1;
      end else if (inflight) begin
        pc_1_n = ret_pc1;
        ir_n   = IM_data;
        bp_n   = 1'b1;
      end else begin
        ir_n = NOP_IR;
        bp_n = 1'b0;
      end
    end
  end

  // State and decode-facing output registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc             <= RESET_PC;
      inflight_pc    <= '0;
      inflight       <= 1'b0;
      count          <= '0;
      head           <= '0;
      PC_1           <= '0;
      IR             <= NOP_IR;
      branch_predict <= 1'b0;
    end else begin
      pc             <= pc_n;
      inflight_pc    <= inflight_pc_n;
      inflight       <= inflight_n;
      count          <= count_n;
      head           <= head_n;
      PC_1           <= pc_1_n;
      IR             <= ir_n;
      branch_predict <= bp_n;
    end
  end

  // Prefetch buffer storage; returning word lands at the tail
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_pc1[i] <= '0;
        buf_ir[i]  <= '0;
      end
    end else if (push) begin
      buf_pc1[tail] <= ret_pc1;
      buf_ir[tail]  <= IM_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: synchronous memory model, scoreboard of
// expected {PC_1, IR} in address order, and per-scenario timing checks.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        reset;
  logic        stall;
  logic        take_branch;
  logic [7:0]  BrA;
  logic [7:0]  IM_addr;
  logic [31:0] IM_data;
  logic [7:0]  PC_1;
  logic [31:0] IR;
  logic        branch_predict;

  typedef struct packed {
    logic [7:0]  pc1;
    logic [31:0] ir;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch_stage dut (
    .CLK            (CLK),
    .reset          (reset),
    .stall          (stall),
    .take_branch    (take_branch),
    .BrA            (BrA),
    .IM_addr        (IM_addr),
    .IM_data        (IM_data),
    .PC_1           (PC_1),
    .IR             (IR),
    .branch_predict (branch_predict)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  always @(posedge CLK) IM_data <= mem_word(IM_addr);

  task automatic push_stream(input logic [7:0] start, input int n);
    logic [7:0] a;
    exp_t       e;
    for (int i = 0; i < n; i++) begin
      a     = start + 8'(i);
      e.pc1 = a + 8'd1;
      e.ir  = mem_word(a);
      sbq.push_back(e);
    end
  endtask

  // Advance one edge; an accepted instruction is popped from the scoreboard
  task automatic tick();
    logic acc;
    exp_t e;
    @(posedge CLK);
    acc = !reset && !stall && !take_branch;
    #1;
    if (acc && branch_predict) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got PC_1=%0h IR=%0h, none expected", PC_1, IR);
      end else begin
        e = sbq.pop_front();
        if (PC_1 !== e.pc1 || IR !== e.ir) begin
          errors++;
          $display("FAIL stream_order: got PC_1=%0h IR=%0h expected PC_1=%0h IR=%0h",
                   PC_1, IR, e.pc1, e.ir);
        end
      end
    end
    if (!reset) begin
      checks++;
      if (dut.count > 2'd2) begin
        errors++;
        $display("FAIL buffer_overflow: got count=%0d expected <= 2", dut.count);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; take_branch = 1'b0; BrA = 8'h00;
    #12;
    checks++;
    if ({PC_1, IR, branch_predict} !== {8'h00, NOP, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %0h/%0h/%0b expected 0/0/0", PC_1, IR, branch_predict);
    end
    checks++;
    if (IM_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_pc: got %0h expected 0", IM_addr);
    end
    tick();
    reset = 1'b0;
    push_stream(8'h00, 5);
    tick();
    checks++;
    if (branch_predict !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_bubble: got bp=%0b expected 0", branch_predict);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (branch_predict !== 1'b1) begin
        errors++;
        $display("FAIL throughput: got bp=%0b expected 1 at step %0d", branch_predict, i);
      end
    end
    checks++;
    if (sbq.size() != 0 || PC_1 !== 8'h05) begin
      errors++;
      $display("FAIL startup_drain: got left=%0d PC_1=%0h expected 0 and 05", sbq.size(), PC_1);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (PC_1 !== 8'h05 || branch_predict !== 1'b1 || IR !== mem_word(8'h04)) begin
        errors++;
        $display("FAIL stall_hold: got PC_1=%0h bp=%0b expected 05/1", PC_1, branch_predict);
      end
    end
    checks++;
    if (dut.count !== 2'd2) begin
      errors++;
      $display("FAIL stall_fill: got count=%0d expected 2", dut.count);
    end
    stall = 1'b0;
    push_stream(8'h05, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (branch_predict !== 1'b1) begin
        errors++;
        $display("FAIL stall_resume: got bp=%0b expected 1", branch_predict);
      end
    end
    checks++;
    if (sbq.size() != 0 || PC_1 !== 8'h08) begin
      errors++;
      $display("FAIL stall_drain: got left=%0d PC_1=%0h expected 0 and 08", sbq.size(), PC_1);
    end
  endtask

  task automatic test_branch();
    push_stream(8'h08, 2);
    tick(); tick();
    take_branch = 1'b1; BrA = 8'h40;
    tick();
    checks++;
    if (branch_predict !== 1'b0 || IR !== NOP || PC_1 !== 8'h0A) begin
      errors++;
      $display("FAIL branch_bubble1: got bp=%0b IR=%0h PC_1=%0h expected 0/0/0a",
               branch_predict, IR, PC_1);
    end
    take_branch = 1'b0;
    tick();
    checks++;
    if (branch_predict !== 1'b0 || IR !== NOP) begin
      errors++;
      $display("FAIL branch_bubble2: got bp=%0b IR=%0h expected 0/0", branch_predict, IR);
    end
    push_stream(8'h40, 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (branch_predict !== 1'b1) begin
        errors++;
        $display("FAIL branch_target_stream: got bp=%0b expected 1", branch_predict);
      end
    end
    checks++;
    if (sbq.size() != 0 || PC_1 !== 8'h44) begin
      errors++;
      $display("FAIL branch_drain: got left=%0d PC_1=%0h expected 0 and 44", sbq.size(), PC_1);
    end
  endtask

  task automatic test_wrap();
    take_branch = 1'b1; BrA = 8'hFC;
    tick();
    take_branch = 1'b0;
    tick();
    checks++;
    if (branch_predict !== 1'b0) begin
      errors++;
      $display("FAIL wrap_bubble: got bp=%0b expected 0", branch_predict);
    end
    push_stream(8'hFC, 6);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (sbq.size() != 0 || PC_1 !== 8'h02) begin
      errors++;
      $display("FAIL wrap_drain: got left=%0d PC_1=%0h expected 0 and 02", sbq.size(), PC_1);
    end
  endtask

  task automatic test_branch_stall_full();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (dut.count !== 2'd2 || PC_1 !== 8'h02) begin
      errors++;
      $display("FAIL full_before_branch: got count=%0d PC_1=%0h expected 2 and 02", dut.count, PC_1);
    end
    take_branch = 1'b1; BrA = 8'h80;
    tick();
    checks++;
    if (branch_predict !== 1'b0 || IR !== NOP || PC_1 !== 8'h02 || dut.count !== 2'd0) begin
      errors++;
      $display("FAIL branch_over_stall: got bp=%0b IR=%0h PC_1=%0h count=%0d expected 0/0/02/0",
               branch_predict, IR, PC_1, dut.count);
    end
    take_branch = 1'b0; stall = 1'b0;
    tick();
    checks++;
    if (branch_predict !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble2: got bp=%0b expected 0", branch_predict);
    end
    push_stream(8'h80, 3);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (sbq.size() != 0 || PC_1 !== 8'h83) begin
      errors++;
      $display("FAIL flush_drain: got left=%0d PC_1=%0h expected 0 and 83", sbq.size(), PC_1);
    end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (dut.count !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_fill: got count=%0d expected 2", dut.count);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({PC_1, IR, branch_predict} !== {8'h00, NOP, 1'b0} || dut.count !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got %0h/%0h/%0b count=%0d expected 0/0/0 count=0",
               PC_1, IR, branch_predict, dut.count);
    end
    sbq.delete();
    stall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    push_stream(8'h00, 4);
    tick();
    checks++;
    if (branch_predict !== 1'b0) begin
      errors++;
      $display("FAIL restart_bubble: got bp=%0b expected 0", branch_predict);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (branch_predict !== 1'b1) begin
        errors++;
        $display("FAIL restart_stream: got bp=%0b expected 1", branch_predict);
      end
    end
    checks++;
    if (sbq.size() != 0 || PC_1 !== 8'h04) begin
      errors++;
      $display("FAIL restart_drain: got left=%0d PC_1=%0h expected 0 and 04", sbq.size(), PC_1);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_wrap();
    test_branch_stall_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Pipeline stage 1 of the 8-bit-PC RISC core. It sits directly upstream of the decode/operand-fetch stage.
- Holds the program counter and drives a synchronous-read instruction memory.
- Absorbs memory latency during stalls with a small prefetch buffer.
- Presents a registered {PC_1, IR, branch_predict} triple to decode.
- On a taken branch from execute it redirects, squashes wrong-path words and inserts bubbles (branch_predict=0).

Parameters:
PC_W, 8, program counter / instruction address width
IR_W, 32, instruction width
DEPTH, 2, prefetch buffer entries (power of two, ≥2)
RESET_PC, 0, PC value after reset
NOP_IR, 32'h0000_0000, IR value driven with bubbles

Ports:
CLK  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
stall  input  1  decode cannot accept; hold decode-facing outputs
take_branch  input  1  execute resolved a taken branch/jump this cycle
BrA  input  PC_W  branch target address
IM_addr  output  PC_W  instruction memory address (= PC register, combinational)
IM_data  input  IR_W  instruction memory read data, valid one cycle after IM_addr
PC_1  output  PC_W  registered address+1 of the instruction in IR
IR  output  IR_W  registered instruction to decode
branch_predict  output  1  1 = IR is a valid, non-squashed instruction

Behaviour:
Reset (async):
- PC=RESET_PC; buffer count=0; inflight=0.
- PC_1=0, IR=NOP_IR, branch_predict=0.

Issue:
- drain = ~stall & (count>0 | inflight).
- issue_en = ~take_branch & (count + inflight − drain < DEPTH).
- On issue_en: inflight<=1, inflight_pc<=PC, PC<=PC+1 (mod 2^PC_W, 8'hFF→8'h00). Otherwise inflight<=0 and PC holds.

Return:
- When inflight=1, IM_data is the word for inflight_pc; its PC_1 is inflight_pc+1.

Decode register load (when ~stall & ~take_branch):
- If count>0: pop buffer head into {PC_1, IR}, branch_predict=1. Any returning word is pushed to the tail.
- Else if inflight: bypass the returning word directly, branch_predict=1.
- Else: IR=NOP_IR, branch_predict=0, PC_1 holds.

Stall (stall=1, ~take_branch):
- PC_1/IR/branch_predict hold.
- A returning word is pushed into the buffer.
- Issue throttling guarantees no overflow. Push when count==DEPTH is an error the bench must flag.

take_branch (highest priority below reset, overrides stall):
- PC<=BrA; count<=0; inflight<=0, so the word returning next cycle is discarded.
- IR<=NOP_IR, branch_predict<=0; PC_1 holds.
- Redirect latency: branch seen at edge k → BrA issued in cycle k..k+1 → decode receives instr@BrA at edge k+2. This gives exactly 2 bubbles.

Throughput:
- With stall=0 and no branch: one instruction per cycle.
- First valid instruction appears at the 2nd rising edge after reset deassert: PC_1=RESET_PC+1.

Simultaneous events:
- take_branch & stall: branch wins and decode outputs are overwritten with a bubble.
- take_branch with buffer full: all entries flushed.
- stall deassert with buffer full: pop head; issue resumes the same cycle.

Ordering:
- Instructions reach decode in strict address order between redirects.
- No duplication, no loss.

Reset mid-operation:
- All buffer contents and the in-flight word are dropped.
- Fetch restarts at RESET_PC.

Test Plan:
1. Reset release, IM returns mem[a]=32'h1000_0000+a, stall=0 → edge 2: PC_1=1, IR=32'h1000_0000, branch_predict=1; then PC_1=2,3,4… every cycle.
2. Steady stream, stall high 3 cycles at PC_1=5 → outputs hold PC_1=5 throughout; count reaches 2 with no overflow; after release PC_1=6,7,8 on consecutive edges, none missing or repeated.
3. take_branch=1, BrA=8'h40 at PC_1=10 → next two edges branch_predict=0, IR=NOP_IR; third edge PC_1=8'h41, IR=mem[8'h40], branch_predict=1.
4. take_branch asserted while stall=1 and buffer full → buffer flushed; bubble presented; stream resumes at BrA with 2-bubble latency; no stale word appears.
5. Stream through PC=8'hFE,8'hFF → PC_1 sequence FF,00,01 with IR=mem[FE],mem[FF],mem[00].
6. Assert reset asynchronously mid-cycle while stalled with count=2 → outputs immediately PC_1=0, IR=0, branch_predict=0; after release, behaviour identical to scenario 1.
